// File: rtl/wb_pkg.sv
// Shared constants and the register-address type for the write-back register file and its scoreboard.
// Include this package before any file that imports it.
package wb_pkg;
    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 2;
    localparam int NREG       = 4;
    localparam int PEND_MAX   = 3;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [1:0]            pend_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Purpose: per-register pending-write counters that gate issue; bypass relax under WB_REGFILE_BYPASS_EN.
// Latency: counters update on the next edge; id_stall is combinational.
// Backpressure: id_stall holds decode on busy sources or a saturated destination, and never depends on id_issue.
module wb_scoreboard
    import wb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      wb_reg_write,
    input  reg_addr_t wb_reg_dist,
    input  reg_addr_t id_rs1,
    input  reg_addr_t id_rs2,
    input  logic      id_issue,
    input  logic      id_rd_valid,
    input  reg_addr_t id_rd,
    output logic      id_stall
);

    pend_t [NREG-1:0] pend_q;
    pend_t [NREG-1:0] pend_d;
    logic             issue_acc;

    function automatic logic src_busy(input reg_addr_t rs, input pend_t cnt);
`ifdef WB_REGFILE_BYPASS_EN
        // The final outstanding write to this source is landing now and is forwarded.
        src_busy = (cnt != 2'd0) &&
                   !((cnt == 2'd1) && wb_reg_write && (wb_reg_dist == rs));
`else
        src_busy = (cnt != 2'd0);
`endif
    endfunction

    always_comb begin
        id_stall = src_busy(id_rs1, pend_q[id_rs1]) ||
                   src_busy(id_rs2, pend_q[id_rs2]) ||
                   (id_rd_valid && (pend_q[id_rd] == pend_t'(PEND_MAX)));
        issue_acc = id_issue && id_rd_valid && !id_stall;
    end

    always_comb begin
        pend_d = pend_q;
        for (int r = 0; r < NREG; r++) begin
            if (issue_acc && (id_rd == reg_addr_t'(r))) begin
                // A commit to the same register in the same cycle cancels the increment.
                if (!(wb_reg_write && (wb_reg_dist == reg_addr_t'(r)))) begin
                    pend_d[r] = pend_q[r] + 2'd1;
                end
            end else if (wb_reg_write && (wb_reg_dist == reg_addr_t'(r)) && (pend_q[r] != 2'd0)) begin
                pend_d[r] = pend_q[r] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Purpose: register array with zero-latency reads, retire counter and scoreboard; WB_REGFILE_BYPASS_EN forwards wb_result.
// Latency: commits visible next cycle (same cycle with bypass); reads are combinational.
// Backpressure: id_stall from the scoreboard; commits are always accepted.
module wb_regfile #(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int NREG   = wb_pkg::NREG
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_reg_write,
    input  wb_pkg::reg_addr_t     wb_reg_dist,
    input  logic [DATA_W-1:0]     wb_result,
    input  wb_pkg::reg_addr_t     id_rs1,
    input  wb_pkg::reg_addr_t     id_rs2,
    output logic [DATA_W-1:0]     id_rs1_data,
    output logic [DATA_W-1:0]     id_rs2_data,
    input  logic                  id_issue,
    input  logic                  id_rd_valid,
    input  wb_pkg::reg_addr_t     id_rd,
    output logic                  id_stall,
    output logic [15:0]           retire_cnt
);

    logic [NREG-1:0][DATA_W-1:0] regs_q;
    logic [NREG-1:0][DATA_W-1:0] regs_d;
    logic [15:0]                 retire_cnt_q;
    logic [15:0]                 retire_cnt_d;

    always_comb begin
        regs_d       = regs_q;
        retire_cnt_d = retire_cnt_q;
        if (wb_reg_write) begin
            regs_d[wb_reg_dist] = wb_result;
            if (retire_cnt_q != 16'hFFFF) begin
                retire_cnt_d = retire_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q       <= '0;
            retire_cnt_q <= '0;
        end else begin
            regs_q       <= regs_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    always_comb begin
`ifdef WB_REGFILE_BYPASS_EN
        id_rs1_data = (wb_reg_write && (wb_reg_dist == id_rs1)) ? wb_result : regs_q[id_rs1];
        id_rs2_data = (wb_reg_write && (wb_reg_dist == id_rs2)) ? wb_result : regs_q[id_rs2];
`else
        id_rs1_data = regs_q[id_rs1];
        id_rs2_data = regs_q[id_rs2];
`endif
    end

    assign retire_cnt = retire_cnt_q;

    wb_scoreboard u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .wb_reg_write (wb_reg_write),
        .wb_reg_dist  (wb_reg_dist),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_issue     (id_issue),
        .id_rd_valid  (id_rd_valid),
        .id_rd        (id_rd),
        .id_stall     (id_stall)
    );

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DATA_W, 8, register and result data width SHALL be DATA_W bits.
REQ-002 Parameter NREG, 4, number of architectural registers SHALL be NREG; address width SHALL be 2 bits.
REQ-003 Port clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  in  1  reset SHALL be synchronous and active-high.
REQ-005 Port wb_reg_write  in  1  write-back commit strobe from the MEM/WB stage.
REQ-006 Port wb_reg_dist  in  2  write-back destination register.
REQ-007 Port wb_result  in  8  write-back data.
REQ-008 Ports id_rs1, id_rs2  in  2 each  decode-stage source register addresses.
REQ-009 Ports id_rs1_data, id_rs2_data  out  8 each  source operand data, combinational.
REQ-010 Port id_issue  in  1  decode requests to issue the current instruction.
REQ-011 Port id_rd_valid  in  1  issuing instruction writes a register.
REQ-012 Port id_rd  in  2  issuing instruction's destination register.
REQ-013 Port id_stall  out  1  combinational; decode SHALL hold its instruction while it is high.
REQ-014 Port retire_cnt  out  16  count of committed write-backs.

Function
REQ-015 Commit: when wb_reg_write=1 at a clock edge, the module SHALL write wb_result to regs[wb_reg_dist]; all registers, including R0, SHALL be writable.
REQ-016 Read: each idN_data SHALL equal regs[id_rsN] in the same cycle (zero-latency read).
REQ-017 Scoreboard: each register SHALL have a 2-bit pending count pend[r], range 0..3.
REQ-018 Accepted issue is id_issue & id_rd_valid & ~id_stall; it SHALL increment pend[id_rd] at the next edge.
REQ-019 A wb_reg_write with pend[wb_reg_dist]>0 SHALL decrement pend[wb_reg_dist]; a write with count 0 SHALL leave the count at 0, and the data write SHALL still occur.
REQ-020 An accepted issue and a commit to the same register in the same cycle SHALL leave pend unchanged.
REQ-021 id_stall SHALL be high when pend[id_rs1]!=0 or pend[id_rs2]!=0, except as relaxed by REQ-027.
REQ-022 id_stall SHALL also be high when id_rd_valid=1 and pend[id_rd]=3 (saturation); the count SHALL never wrap.
REQ-023 id_stall SHALL be independent of id_issue; there is no combinational path id_issue->id_stall.
REQ-024 retire_cnt SHALL increment by 1 per wb_reg_write and saturate at 0xFFFF.

Reset
REQ-025 While rst=1 at an edge, all regs, all pend counts and retire_cnt SHALL become 0; rst SHALL take priority over a simultaneous commit or issue.
REQ-026 After reset, id_stall SHALL be 0 and id_rsN_data SHALL read 0 until the first commit.

Configuration
REQ-027 With macro WB_REGFILE_BYPASS_EN defined:
- id_rsN_data SHALL return wb_result when wb_reg_write=1 and wb_reg_dist=id_rsN.
- A source whose pend=1 and is being committed in the same cycle SHALL NOT assert id_stall.
REQ-028 Without WB_REGFILE_BYPASS_EN: reads SHALL return array contents only, and any nonzero pend on a source SHALL stall.

Structure
REQ-029 Package wb_pkg SHALL hold DATA_W, REG_ADDR_W=2, NREG=4, PEND_MAX=3 and the register-address typedef.
REQ-030 The scoreboard (pend counters, saturation and stall logic) SHALL be the sub-module wb_scoreboard; the array, read muxes and retire counter SHALL reside in wb_regfile.

Verification
REQ-031 Reset, then commit R2=0x5A; next cycle id_rs1=2 -> id_rs1_data=0x5A and retire_cnt=1.
REQ-032 Issue rd=R1; next cycle id_rs1=1 -> id_stall=1; commit R1=0x33 -> with BYPASS_EN, stall=0 and data=0x33 in the commit cycle; without it, stall=0 and data=0x33 one cycle later.
REQ-033 Issue rd=R3 three times with no commits -> pend[R3]=3; fourth issue with id_rd=3 -> id_stall=1 and the count stays 3.
REQ-034 Accepted issue rd=R0 and commit to R0 in the same cycle with pend[R0]=1 -> pend[R0] stays 1 and the data write occurs.
REQ-035 Preload retire_cnt to 0xFFFE by commits, then perform 3 commits -> retire_cnt=0xFFFF; assert rst together with a commit -> all state 0 and no write.
